// File: rtl/tournament_pair_selector.sv
// Draws parent pairs by 2-way tournament over latched sorted ranks and streams them downstream.
// Optional ELITISM_EN: the first pair of each generation is (rank[0], rank[1]) with no draw.
module tournament_pair_selector #(
  parameter int unsigned POP_SIZE  = 50,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned NUM_PAIRS = 25,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [POP_SIZE*IDX_W-1:0] sorted_in,
  output logic                      pair_valid,
  input  logic                      pair_ready,
  output logic [IDX_W-1:0]          parent_a,
  output logic [IDX_W-1:0]          parent_b,
  output logic [5:0]                pair_count,
  output logic                      busy,
  output logic                      done
);

  localparam logic [5:0] NumPairs6 = 6'(NUM_PAIRS);

  typedef enum logic [1:0] {StIdle, StDraw, StPresent, StDone} state_e;

  state_e                    state_q, state_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [1:0]                sub_q, sub_d;
  logic [IDX_W-1:0]          ra0_q, ra0_d, ra1_q, ra1_d, rb0_q, rb0_d;
  logic [IDX_W-1:0]          pa_q, pa_d, pb_q, pb_d;
  logic [5:0]                cnt_q, cnt_d;
  logic [POP_SIZE*IDX_W-1:0] ranks_q, ranks_d;
  logic [IDX_W-1:0]          draw_rank;

  // Fold the 6-bit LFSR slice into 0..POP_SIZE-1 with a single subtraction.
  function automatic logic [IDX_W-1:0] reduce_rank(input logic [5:0] v);
    int unsigned t;
    t = 32'(v);
    if (t >= POP_SIZE) t = t - POP_SIZE;
    return t[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] min_rank(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [IDX_W-1:0] lookup(input logic [POP_SIZE*IDX_W-1:0] vec,
                                              input logic [IDX_W-1:0]          r);
    return vec[IDX_W*r +: IDX_W];
  endfunction

  assign draw_rank = reduce_rank(lfsr_q[5:0]);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sub_d   = sub_q;
    ra0_d   = ra0_q;
    ra1_d   = ra1_q;
    rb0_d   = rb0_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    cnt_d   = cnt_q;
    ranks_d = ranks_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          ranks_d = sorted_in;
          cnt_d   = '0;
          sub_d   = '0;
`ifdef ELITISM_EN
          pa_d    = sorted_in[0 +: IDX_W];
          pb_d    = sorted_in[IDX_W +: IDX_W];
          state_d = StPresent;
`else
          state_d = StDraw;
`endif
        end
      end
      StDraw: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        sub_d  = sub_q + 2'd1;
        unique case (sub_q)
          2'd0: ra0_d = draw_rank;
          2'd1: ra1_d = draw_rank;
          2'd2: rb0_d = draw_rank;
          2'd3: begin
            // rb1 is used straight from the LFSR, never stored.
            pa_d    = lookup(ranks_q, min_rank(ra0_q, ra1_q));
            pb_d    = lookup(ranks_q, min_rank(rb0_q, draw_rank));
            state_d = StPresent;
          end
          default: ;
        endcase
      end
      StPresent: begin
        if (pair_ready) begin
          cnt_d   = cnt_q + 6'd1;
          sub_d   = '0;
          state_d = (cnt_q + 6'd1 == NumPairs6) ? StDone : StDraw;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      sub_q   <= '0;
      ra0_q   <= '0;
      ra1_q   <= '0;
      rb0_q   <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      cnt_q   <= '0;
      ranks_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sub_q   <= sub_d;
      ra0_q   <= ra0_d;
      ra1_q   <= ra1_d;
      rb0_q   <= rb0_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      cnt_q   <= cnt_d;
      ranks_q <= ranks_d;
    end
  end

  assign pair_valid = (state_q == StPresent);
  assign busy       = (state_q == StDraw) || (state_q == StPresent);
  assign done       = (state_q == StDone);
  assign parent_a   = pa_q;
  assign parent_b   = pb_q;
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_tournament_pair_selector.sv
// Directed bench for tournament_pair_selector (default build, ELITISM_EN undefined).
module tb_tournament_pair_selector;

  localparam int P = 50;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [P*W-1:0] sorted_in = '0;
  logic           pair_valid;
  logic           pair_ready = 1'b0;
  logic [W-1:0]   parent_a, parent_b;
  logic [5:0]     pair_count;
  logic           busy, done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: LFSR as the spec defines it, and the rank table loaded into sorted_in.
  logic [15:0] m_lfsr;
  int          m_rank [P];

  tournament_pair_selector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sorted_in  (sorted_in),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .parent_a   (parent_a),
    .parent_b   (parent_b),
    .pair_count (pair_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ranks(input bit reversed);
    for (int r = 0; r < P; r++) begin
      m_rank[r] = reversed ? (P - 1 - r) : r;
      sorted_in[W*r +: W] = W'(m_rank[r]);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int lfsr_rank(input logic [15:0] l);
    int v;
    v = int'(l[5:0]);
    return (v >= P) ? v - P : v;
  endfunction

  task automatic predict(output int ea, output int eb);
    int r [4];
    for (int i = 0; i < 4; i++) begin
      r[i]   = lfsr_rank(m_lfsr);
      m_lfsr = lfsr_next(m_lfsr);
    end
    ea = m_rank[(r[0] < r[1]) ? r[0] : r[1]];
    eb = m_rank[(r[2] < r[3]) ? r[2] : r[3]];
  endtask

  initial begin
    int ea, eb, hs, done_edge;

    // Reset state
    m_lfsr = 16'hACE1;
    #3;
    check("rst_valid", 32'(pair_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(pair_count), 0);
    check("rst_pa", 32'(parent_a), 0);
    check("rst_pb", 32'(parent_b), 0);
    step();
    rst_n = 1'b1;
    step();

    // Seeded draw, identity ranks: valid exactly after the 4th edge past start
    load_ranks(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("e0_busy", 32'(busy), 1);
    step();
    step();
    step();
    check("e3_valid", 32'(pair_valid), 0);
    step();
    predict(ea, eb);
    check("e4_valid", 32'(pair_valid), 1);
    check("seed_pa", 32'(parent_a), 3);
    check("seed_pb", 32'(parent_b), 7);

    // Backpressure: everything held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 32'(pair_valid), 1);
      check("bp_pa", 32'(parent_a), 3);
      check("bp_pb", 32'(parent_b), 7);
      check("bp_count", 32'(pair_count), 0);
    end
    pair_ready = 1'b1;
    step();
    pair_ready = 1'b0;
    check("hs_count", 32'(pair_count), 1);
    check("hs_valid", 32'(pair_valid), 0);

    // Start during DRAW is ignored; next pair still lands at H+4 from the frozen LFSR
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("h3_valid", 32'(pair_valid), 0);
    step();
    predict(ea, eb);
    check("h4_valid", 32'(pair_valid), 1);
    check("p2_pa", 32'(parent_a), 32'(ea));
    check("p2_pb", 32'(parent_b), 32'(eb));
    check("p2_count", 32'(pair_count), 1);

    // Asynchronous abort while PRESENT
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(pair_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_count", 32'(pair_count), 0);
    step();
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    step();

    // Full generation, reversed ranks, ready tied high (also proves reseed on reset)
    load_ranks(1'b1);
    pair_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    hs = 0;
    done_edge = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (pair_valid) begin
        predict(ea, eb);
        if (hs == 0) begin
          check("rev_pa", 32'(parent_a), 46);
          check("rev_pb", 32'(parent_b), 42);
        end
        check("gen_pa", 32'(parent_a), 32'(ea));
        check("gen_pb", 32'(parent_b), 32'(eb));
        hs++;
      end
      if (done) begin
        done_edge = k;
        break;
      end
    end
    check("gen_pairs", 32'(hs), 25);
    check("gen_done_edge", 32'(done_edge), 125);
    check("gen_count", 32'(pair_count), 25);
    check("gen_done", 32'(done), 1);
    step();
    check("done_hold_count", 32'(pair_count), 25);
    check("done_hold_valid", 32'(pair_valid), 0);

    // Restart from DONE: LFSR continues rather than reseeding
    pair_ready = 1'b0;
    load_ranks(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs_done", 32'(done), 0);
    check("rs_count", 32'(pair_count), 0);
    step();
    step();
    step();
    step();
    predict(ea, eb);
    check("rs_valid", 32'(pair_valid), 1);
    check("rs_pa", 32'(parent_a), 32'(ea));
    check("rs_pb", 32'(parent_b), 32'(eb));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tournament_pair_selector.md
Name: tournament_pair_selector

Overview:
- Downstream consumer of the population sorter's rank-ordered index vector.
- Once per generation, draws parent pairs by 2-way tournament over sorted ranks, using an internal LFSR.
- Streams each pair to the crossover/mutation stage over a valid/ready handshake.
- Runs until NUM_PAIRS pairs have been accepted, then reports done.

Parameters:
- POP_SIZE, 50, population members (ranks 0..POP_SIZE-1); constraint 32 <= POP_SIZE <= 2^IDX_W.
- IDX_W, 6, width of one individual index.
- NUM_PAIRS, 25, pairs emitted per generation (>=1).
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a generation; sampled in IDLE or DONE only.
- sorted_in  in  POP_SIZE*IDX_W  rank-ordered indices; rank r occupies bits [IDX_W*r +: IDX_W], rank 0 = best.
- pair_valid  out  1  parent pair presented.
- pair_ready  in  1  consumer accepts the pair.
- parent_a  out  IDX_W  first parent index.
- parent_b  out  IDX_W  second parent index.
- pair_count  out  6  pairs accepted so far in this generation.
- busy  out  1  high in DRAW or PRESENT.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; lfsr=LFSR_SEED; latched ranks=0.
  - pair_valid=0, parent_a=0, parent_b=0, pair_count=0, busy=0, done=0.
  - Reset mid-generation aborts immediately. No partial pair is emitted after release.
- States: IDLE, DRAW, PRESENT, DONE (registered FSM).
- IDLE/DONE, start=1 at an edge:
  - Latch sorted_in into an internal rank array.
  - pair_count=0, draw sub-counter=0, go to DRAW; done drops.
- start while busy is ignored. sorted_in is not re-sampled mid-generation.
- DRAW lasts exactly 4 cycles (sub-counter 0..3):
  - Each cycle, v = lfsr[5:0] is reduced to a rank: r = (v >= POP_SIZE) ? v-POP_SIZE : v.
  - Sub 0 -> ra0, 1 -> ra1, 2 -> rb0, 3 -> rb1.
  - The LFSR advances once per DRAW cycle only: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - The rank uses the pre-advance value.
  - On the sub-3 edge, register:
    - parent_a = rank[min(ra0,ra1)]
    - parent_b = rank[min(rb0,rb1)]
    - Then go to PRESENT.
  - Equal ranks are legal. parent_a may equal parent_b; no re-draw.
- PRESENT:
  - pair_valid=1; parent_a/parent_b held stable until the handshake.
  - Handshake = pair_valid & pair_ready at an edge. On it, pair_count increments.
  - If the new count == NUM_PAIRS, go to DONE; else go to DRAW (sub=0).
  - pair_ready while not PRESENT has no effect.
- DONE: done=1 (level), pair_valid=0. parent_a, parent_b and pair_count hold their last values until the next start.
- Latency:
  - Start-sampling edge E0 -> pair_valid high after E4.
  - Handshake edge H -> next pair_valid high after H+4.
  - With pair_ready tied high, one pair per 5 cycles.
- LFSR state persists across generations; only rst_n reseeds it.

Optional Feature:
- Macro ELITISM_EN.
- When defined:
  - The first pair of every generation bypasses DRAW.
  - On the start edge go directly to PRESENT with parent_a = rank[0], parent_b = rank[1].
  - This pair counts toward NUM_PAIRS.
  - LFSR not advanced for it.
  - All later pairs are drawn normally.
- When undefined: all pairs are drawn by tournament; the behaviour above applies unchanged.

Test Plan:
- Reset/seed (ELITISM_EN off):
  - Stimulus: rst_n low then high; sorted_in identity (rank r holds r); start one cycle; pair_ready=1.
  - Required: first pair_valid 4 edges after start; parent_a=3, parent_b=7.
  - Draw values: ranks 33, 3, 7, 15 from LFSR 0xACE1, 0x59C3, 0xB387, 0x670F.
- Reversed ranks:
  - Stimulus: same as above, rank r holds 49-r.
  - Required: parent_a=46, parent_b=42.
- Backpressure:
  - Stimulus: pair_ready=0 for 10 cycles in PRESENT.
  - Required: pair_valid, parent_a and parent_b stable; LFSR frozen; pair_count unchanged. Raising pair_ready gives exactly one increment.
- Full generation:
  - Stimulus: NUM_PAIRS=25, pair_ready=1.
  - Required: exactly 25 handshakes; done=1 and pair_count=25 at 125 edges after start; start in DONE restarts with LFSR continuing, not reseeded.
- Abort and illegal start:
  - Stimulus: start pulsed during DRAW; then rst_n low during PRESENT.
  - Required: start ignored; reset drives pair_valid=0, busy=0, pair_count=0 asynchronously; LFSR returns to 0xACE1.
- ELITISM_EN build:
  - Stimulus: identity ranks, start.
  - Required: pair_valid 1 edge after start with (0,1); second pair is (3,7).
